// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: one shared full_adder, one bit per clock, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state, state_nxt;
  logic [W-1:0]   op_a, op_b, sum_q, sum_shift;
  logic [CW-1:0]  count;
  logic           carry, cout_q;
  logic           accept, last_bit, do_sub;
  logic           fa_sum, fa_carry;

`ifdef SERIAL_ADD_SUB_EN
  assign do_sub = sub;
`else
  assign do_sub = 1'b0;
`endif

  assign ready    = (state == ST_IDLE) || (state == ST_DONE);
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign accept   = start && ready;
  assign last_bit = (count == CW'(W - 1));

  full_adder u_fa (
    .a     (op_a[0]),
    .b     (op_b[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New result bit enters at the MSB so that after W shifts bit 0 sits at sum[0].
  generate
    if (W == 1) begin : g_shift_w1
      assign sum_shift = fa_sum;
    end else begin : g_shift_wn
      assign sum_shift = {fa_sum, sum_q[W-1:1]};
    end
  endgenerate

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = accept ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= a;
        op_b   <= do_sub ? ~b : b;
        carry  <= do_sub | cin;
        count  <= '0;
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else if (state == ST_RUN) begin
        sum_q <= sum_shift;
        carry <= fa_carry;
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        count <= count + CW'(1);
        if (last_bit) cout_q <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (W=8), with sub-mode vectors
// when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  int errors  = 0;
  int checks  = 0;
  int inv_bad = 0;

  serial_add_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // done must never overlap busy, and ready is always the inverse of busy.
  always @(negedge clk) begin
    if (!rst && ((done && busy) || (ready == busy))) inv_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation: accept, count edges until done, check latency, result and hold.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic [W-1:0] es, input logic ec, input bit glitch);
    int n;
    int nb;
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_after_accept"}, busy, 1);
    n  = 0;
    nb = 1;
    while (!done && n < 20) begin
      if (glitch && n == 2) begin start = 1'b1; a = '0; b = '0; end
      if (glitch && n == 3) start = 1'b0;
      step();
      n++;
      if (busy) nb++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_cycles"}, nb, 8);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_sum_hold"}, sum, es);
  endtask

  initial begin
    int  n;
    int  m;
    bit  saw_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) step();
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 0);
    rst = 1'b0;
    step();

    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("5a_33", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1);

    // Back-to-back: start held through RUN and DONE; second operands taken in DONE.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    step();
    a = 8'h7F; b = 8'h01;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("b2b_first_latency", n, 8);
    check("b2b_first_sum", sum, 8'h30);
    check("b2b_first_cout", cout, 0);
    m = 0;
    do begin
      step();
      m++;
      if (m == 1) begin
        check("b2b_reaccept_busy", busy, 1);
        start = 1'b0;
      end
    end while (!done && m < 20);
    check("b2b_done_spacing", m, 9);
    check("b2b_second_sum", sum, 8'h80);
    check("b2b_second_cout", cout, 0);
    step();

    // Reset after four bit-cycles aborts the operation.
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("abort_mid_state", dut.state, ST_RUN);
    rst = 1'b1;
    step();
    check("abort_state", dut.state, ST_IDLE);
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run_op("01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("sub_07_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    sub = 1'b0;
`endif

    check("invariants", inv_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
